// File: rtl/detector_scheduler.sv
// detector_scheduler: round-robin arbiter that serializes one requester's word into a shared
// serial pattern detector and reports the match count. Define DETCTL_LSB_FIRST_EN for LSB-first shifting.
module detector_scheduler #(
  parameter int N_REQ      = 2,
  parameter int WORD_W     = 8,
  parameter int FLUSH_BITS = 2,
  parameter int DET_LAT    = 1,
  parameter int CNT_W      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WORD_W-1:0]   word,
  output logic [N_REQ-1:0]          grant,
  output logic                      done,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      busy,
  output logic [2:0]                state_out,
  output logic                      det_data,
  input  logic                      det_out
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = $clog2(WORD_W + FLUSH_BITS + DET_LAT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    FLUSH  = 3'b001,
    SHIFT  = 3'b010,
    DRAIN  = 3'b011,
    REPORT = 3'b100
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     phase, phase_nxt;
  logic [IW-1:0]     last_gnt, gnt_idx, pick;
  logic              pick_vld;
  int                rr_idx;
  logic [WORD_W-1:0] shreg, pick_word, shift_src, shifted;
  logic              head;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [DET_LAT:0]  vld_pipe;
  logic              win;

  assign state_out = state;

  // Scan downward so the nearest requester after last_gnt is the last (winning) assignment.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_idx   = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      rr_idx = (int'(last_gnt) + k) % N_REQ;
      if (req[IW'(rr_idx)]) begin
        pick     = IW'(rr_idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    pick_word = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick == IW'(i)) pick_word = word[i*WORD_W +: WORD_W];
  end

  // On the grant edge the word is not latched yet, so shift straight from the input.
  assign shift_src = (state == IDLE) ? pick_word : shreg;

`ifdef DETCTL_LSB_FIRST_EN
  assign head    = shift_src[0];
  assign shifted = shift_src >> 1;
`else
  assign head    = shift_src[WORD_W-1];
  assign shifted = shift_src << 1;
`endif

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = (FLUSH_BITS == 0) ? SHIFT : FLUSH;
          phase_nxt = '0;
        end
      end
      FLUSH: begin
        if (phase == PW'(FLUSH_BITS - 1)) begin
          state_nxt = SHIFT;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      SHIFT: begin
        if (phase == PW'(WORD_W - 1)) begin
          state_nxt = (DET_LAT == 0) ? REPORT : DRAIN;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      DRAIN: begin
        if (phase == PW'(DET_LAT - 1)) begin
          state_nxt = REPORT;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      REPORT:  state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  // vld_pipe[0] tracks SHIFT cycles; the tap DET_LAT stages later is the count window.
  assign win = vld_pipe[DET_LAT];

  always_comb begin
    count_nxt = count;
    if (win && det_out && (count != {CNT_W{1'b1}}))
      count_nxt = count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      grant     <= '0;
      gnt_idx   <= '0;
      last_gnt  <= IW'(N_REQ - 1);
      shreg     <= '0;
      det_data  <= 1'b0;
      count     <= '0;
      match_cnt <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == REPORT);
      vld_pipe <= (vld_pipe << 1) | (DET_LAT + 1)'(state_nxt == SHIFT);
      count    <= count_nxt;
      det_data <= 1'b0;
      if (state == IDLE && pick_vld) begin
        grant   <= N_REQ'(1) << pick;
        gnt_idx <= pick;
        count   <= '0;
        shreg   <= pick_word;
      end
      if (state_nxt == SHIFT) begin
        det_data <= head;
        shreg    <= shifted;
      end
      if (state_nxt == REPORT) match_cnt <= count_nxt;
      if (state == REPORT) last_gnt <= gnt_idx;
      if (state_nxt == IDLE) grant <= '0;
    end
  end

endmodule

// File: tb/tb_detector_scheduler.sv
// Directed bench for detector_scheduler: overlapping "101" detector model on the main instance,
// match-every-one detector on a CNT_W=2 instance for saturation.
`timescale 1ns/1ps
module tb_detector_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b11;
  logic [15:0] word = 16'h00AA;
  logic [1:0]  grant;
  logic        done, busy, det_data;
  logic        det_out = 1'b0;
  logic [3:0]  match_cnt;
  logic [2:0]  state_out;
  logic [2:0]  hist = 3'b000;

  logic [1:0]  req_b = 2'b00;
  logic [15:0] word_b = 16'h0000;
  logic [1:0]  grant_b;
  logic        done_b, busy_b, det_data_b;
  logic        det_out_b = 1'b0;
  logic [1:0]  match_cnt_b;
  logic [2:0]  state_out_b;

  int n_chk = 0;
  int n_err = 0;

  detector_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .word(word), .grant(grant), .done(done),
    .match_cnt(match_cnt), .busy(busy), .state_out(state_out), .det_data(det_data),
    .det_out(det_out)
  );

  detector_scheduler #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req(req_b), .word(word_b), .grant(grant_b), .done(done_b),
    .match_cnt(match_cnt_b), .busy(busy_b), .state_out(state_out_b), .det_data(det_data_b),
    .det_out(det_out_b)
  );

  always #5 clk = ~clk;

  // Detector models, one cycle of latency each.
  always @(posedge clk) begin
    hist      <= {hist[1:0], det_data};
    det_out   <= ({hist[1:0], det_data} == 3'b101);
    det_out_b <= det_data_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected det_data over the 10 cycles after grant: two flush zeros, then the word.
  function automatic logic [9:0] exp_seq(input logic [7:0] w);
    logic [9:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef DETCTL_LSB_FIRST_EN
      e = {e[8:0], w[i]};
`else
      e = {e[8:0], w[7-i]};
`endif
    end
    return e;
  endfunction

  task automatic run_txn(input logic [1:0] exp_gnt, input logic [7:0] w,
                         input logic [3:0] exp_cnt, input logic mutate, input string tag);
    int n;
    int lat;
    logic [9:0] seq;
    n = 0;
    while (grant == 2'b00 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (grant == 2'b00) begin
      chk({tag, "_grant_timeout"}, 32'(1), 32'(0));
      return;
    end
    chk({tag, "_grant"}, 32'(grant), 32'(exp_gnt));
    chk({tag, "_wait"}, 32'(n), 32'(1));
    chk({tag, "_flush_state"}, 32'(state_out), 32'(3'b001));
    chk({tag, "_busy"}, 32'(busy), 32'(1));
    seq = '0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(posedge clk); #1; lat++;
      end
      if (mutate && i == 4) begin
        req  = 2'b00;
        word = 16'hFFFF;
      end
      seq = {seq[8:0], det_data};
    end
    chk({tag, "_seq"}, 32'(seq), 32'(exp_seq(w)));
    while (!done && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_done"}, 32'(done), 32'(1));
    chk({tag, "_latency"}, 32'(lat), 32'(11));
    chk({tag, "_cnt"}, 32'(match_cnt), 32'(exp_cnt));
    chk({tag, "_grant_held"}, 32'(grant), 32'(exp_gnt));
    chk({tag, "_report_state"}, 32'(state_out), 32'(3'b100));
    @(posedge clk); #1;
    chk({tag, "_idle_grant"}, 32'(grant), 32'(0));
    chk({tag, "_idle_state"}, 32'(state_out), 32'(0));
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ndone;
    // Reset held with both requests active.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_grant", 32'(grant), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_state", 32'(state_out), 32'(0));
      chk("rst_det", 32'(det_data), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_cnt", 32'(match_cnt), 32'(0));
    end
    rst  = 1'b0;
    req  = 2'b01;
    word = 16'h00AA;
    run_txn(2'b01, 8'hAA, 4'd3, 1'b0, "single");
    req = 2'b00;
    repeat (3) begin @(posedge clk); #1; end
    chk("cnt_hold", 32'(match_cnt), 32'(3));

    // req dropped and word changed mid-SHIFT.
    req  = 2'b01;
    word = 16'h00AA;
    run_txn(2'b01, 8'hAA, 4'd3, 1'b1, "midop");

    // Reset asserted during SHIFT.
    req  = 2'b01;
    word = 16'h00AA;
    n = 0;
    while (grant == 2'b00 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("abort_pre_state", 32'(state_out), 32'(3'b010));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", 32'(state_out), 32'(0));
    chk("abort_grant", 32'(grant), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_det", 32'(det_data), 32'(0));
    rst = 1'b0;
    req = 2'b00;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      ndone += int'(done);
      @(posedge clk); #1;
    end
    chk("abort_nodone", 32'(ndone), 32'(0));

    // Round robin with both requests held.
    req  = 2'b11;
    word = 16'h0500;
    run_txn(2'b01, 8'h00, 4'd0, 1'b0, "rr0");
    run_txn(2'b10, 8'h05, 4'd1, 1'b0, "rr1");
    run_txn(2'b01, 8'h00, 4'd0, 1'b0, "rr2");
    req = 2'b00;

    // Bit order.
    @(posedge clk); #1;
    req  = 2'b01;
    word = 16'h0001;
    run_txn(2'b01, 8'h01, 4'd0, 1'b0, "order");
    req = 2'b00;

    // Saturation on the CNT_W=2 instance.
    req_b  = 2'b01;
    word_b = 16'h00AA;
    n = 0;
    while (!done_b && n < 30) begin
      @(posedge clk); #1; n++;
      if (n == 2) req_b = 2'b00;
    end
    chk("sat_done", 32'(done_b), 32'(1));
    chk("sat_latency", 32'(n), 32'(12));
    chk("sat_cnt", 32'(match_cnt_b), 32'(3));
    chk("sat_grant", 32'(grant_b), 32'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
